// File: rtl/encoder_1553_fifo.sv
// encoder_1553_fifo
//   MIL-STD-1553 Manchester II word encoder fed by a word FIFO. Queued words
//   are sent back to back with no inter-word gap. Each frame is 40 half-bits:
//   6 sync half-bits (csw 111000, dw 000111), 16 data bits MSB first
//   (1 -> 10, 0 -> 01), then an odd parity bit. Each half-bit lasts
//   HALF_BIT_CLKS enc_clk cycles.
//
// Parameters
//   FIFO_DEPTH     queued words, power of 2, 2..16
//   HALF_BIT_CLKS  enc_clk cycles per half-bit, 1..64
//
// Ports
//   enc_clk      encoder clock, rising edge
//   rst_n        asynchronous active-low reset
//   tx_word      word to queue, bit 15 sent first
//   tx_csw       write strobe, command/status word (wins if both strobes set)
//   tx_dw        write strobe, data word
//   tx_ready     FIFO not full
//   tx_busy      FIFO non-empty or word in flight
//   tx_data      Manchester output, positive leg
//   tx_data_n    negative leg, ~tx_data while tx_dval, else 0
//   tx_dval      a half-bit is being driven
//   tx_dval_csw  word in flight is a command/status word
//   tx_done      pulse on the final clock of a word's last half-bit
//   tx_overflow  pulse when a write is dropped on a full FIFO
//
// Optional build macro ENCODER_1553_PARITY_INJ_EN adds inputs tx_par_err
// (send even parity) and tx_sync_err (send the other type's sync pattern),
// both stored per FIFO entry.
module encoder_1553_fifo #(
  parameter int FIFO_DEPTH    = 4,
  parameter int HALF_BIT_CLKS = 1
) (
  input  logic        enc_clk,
  input  logic        rst_n,
  input  logic [15:0] tx_word,
  input  logic        tx_csw,
  input  logic        tx_dw,
`ifdef ENCODER_1553_PARITY_INJ_EN
  input  logic        tx_par_err,
  input  logic        tx_sync_err,
`endif
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_data,
  output logic        tx_data_n,
  output logic        tx_dval,
  output logic        tx_dval_csw,
  output logic        tx_done,
  output logic        tx_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
`ifdef ENCODER_1553_PARITY_INJ_EN
  localparam int EW = 19;
`else
  localparam int EW = 17;
`endif

  localparam logic [PW-1:0] PLAST     = PW'(HALF_BIT_CLKS - 1);
  localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SYNC = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  localparam logic [5:0] HB_SYNC_LAST  = 6'd5;
  localparam logic [5:0] HB_DATA_FIRST = 6'd6;
  localparam logic [5:0] HB_LAST       = 6'd39;
  localparam logic [5:0] SYNC_CSW      = 6'b111000;
  localparam logic [5:0] SYNC_DW       = 6'b000111;

  // FIFO
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic          w_empty, w_full, w_wr, w_push, w_pop, w_drop;
  logic [EW-1:0] w_entry, w_head;
  logic [15:0]   w_head_word;
  logic          w_head_csw, w_head_par, w_head_sync_csw;
  logic [5:0]    w_head_sync;

  // Encoder
  logic [1:0]    r_state, w_state_n;
  logic [PW-1:0] r_pcnt, w_pcnt_n;
  logic [5:0]    r_hidx, w_hidx_n, w_hidx_inc;
  logic [5:0]    r_sync, w_sync_n;
  logic [16:0]   r_shift, w_shift_n;
  logic          r_tx_data, w_data_n;
  logic          r_tx_dval, w_dval_n;
  logic          r_dval_csw, w_csw_n;
  logic          r_done, w_done_n;
  logic          r_ovf;
  logic          w_active, w_hb_end, w_word_end;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr    = tx_csw | tx_dw;
  // A pop in the same cycle frees the slot, so a write to a full FIFO lands.
  assign w_push  = w_wr && (!w_full || w_pop);
  assign w_drop  = w_wr && w_full && !w_pop;

`ifdef ENCODER_1553_PARITY_INJ_EN
  assign w_entry         = {tx_sync_err, tx_par_err, tx_csw, tx_word};
  assign w_head          = r_mem[r_rptr[AW-1:0]];
  assign w_head_par      = ~^w_head[15:0] ^ w_head[17];
  assign w_head_sync_csw = w_head[16] ^ w_head[18];
`else
  assign w_entry         = {tx_csw, tx_word};
  assign w_head          = r_mem[r_rptr[AW-1:0]];
  assign w_head_par      = ~^w_head[15:0];
  assign w_head_sync_csw = w_head[16];
`endif
  assign w_head_word = w_head[15:0];
  assign w_head_csw  = w_head[16];
  assign w_head_sync = w_head_sync_csw ? SYNC_CSW : SYNC_DW;

  always_ff @(posedge enc_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  assign w_active   = (r_state == S_SYNC) || (r_state == S_DATA);
  assign w_hb_end   = (r_pcnt == PLAST);
  assign w_word_end = w_active && w_hb_end && (r_hidx == HB_LAST);
  // The next word is popped and preloaded in the last cycle of the current
  // parity half-bit so the line stays continuous.
  assign w_pop      = (r_state == S_LOAD) || (w_word_end && !w_empty);
  assign w_hidx_inc = r_hidx + 6'd1;

  always_comb begin
    w_state_n = r_state;
    w_pcnt_n  = r_pcnt;
    w_hidx_n  = r_hidx;
    w_sync_n  = r_sync;
    w_shift_n = r_shift;
    w_data_n  = r_tx_data;
    w_dval_n  = r_tx_dval;
    w_csw_n   = r_dval_csw;

    case (r_state)
      S_IDLE: if (!w_empty) w_state_n = S_LOAD;
      S_SYNC, S_DATA: begin
        if (w_hb_end) begin
          w_pcnt_n = '0;
          if (r_hidx == HB_LAST) begin
            w_state_n = S_IDLE;
            w_hidx_n  = '0;
            w_data_n  = 1'b0;
            w_dval_n  = 1'b0;
            w_csw_n   = 1'b0;
          end else begin
            w_hidx_n = w_hidx_inc;
            if (w_hidx_inc <= HB_SYNC_LAST) begin
              w_sync_n = {r_sync[4:0], 1'b0};
              w_data_n = r_sync[4];
            end else if (w_hidx_inc == HB_DATA_FIRST) begin
              w_state_n = S_DATA;
              w_data_n  = r_shift[16];
            end else if (w_hidx_inc[0]) begin
              // second half of a bit: complement of the first half
              w_data_n = ~r_shift[16];
            end else begin
              w_shift_n = {r_shift[15:0], 1'b0};
              w_data_n  = r_shift[15];
            end
          end
        end else begin
          w_pcnt_n = r_pcnt + PCNT_ONE;
        end
      end
      default: ;
    endcase

    if (w_pop) begin
      w_state_n = S_SYNC;
      w_pcnt_n  = '0;
      w_hidx_n  = '0;
      w_sync_n  = w_head_sync;
      w_shift_n = {w_head_word, w_head_par};
      w_data_n  = w_head_sync[5];
      w_dval_n  = 1'b1;
      w_csw_n   = w_head_csw;
    end

    w_done_n = ((w_state_n == S_SYNC) || (w_state_n == S_DATA)) &&
               (w_hidx_n == HB_LAST) && (w_pcnt_n == PLAST);
  end

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pcnt     <= '0;
      r_hidx     <= '0;
      r_sync     <= '0;
      r_shift    <= '0;
      r_tx_data  <= 1'b0;
      r_tx_dval  <= 1'b0;
      r_dval_csw <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pcnt     <= w_pcnt_n;
      r_hidx     <= w_hidx_n;
      r_sync     <= w_sync_n;
      r_shift    <= w_shift_n;
      r_tx_data  <= w_data_n;
      r_tx_dval  <= w_dval_n;
      r_dval_csw <= w_csw_n;
      r_done     <= w_done_n;
      r_ovf      <= w_drop;
    end
  end

  assign tx_ready    = !w_full;
  assign tx_busy     = !w_empty || r_tx_dval;
  assign tx_data     = r_tx_data;
  assign tx_data_n   = r_tx_dval & ~r_tx_data;
  assign tx_dval     = r_tx_dval;
  assign tx_dval_csw = r_dval_csw;
  assign tx_done     = r_done;
  assign tx_overflow = r_ovf;

endmodule

// File: tb/tb_encoder_1553_fifo.sv
// Testbench for encoder_1553_fifo: two instances (1 and 4 clocks per
// half-bit). Expected line activity is computed from word-level frames.
module tb_encoder_1553_fifo;

  localparam int MAXK = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tx_word;
  logic        tx_csw, tx_dw;
  logic        tx_ready, tx_busy, tx_data, tx_data_n, tx_dval;
  logic        tx_dval_csw, tx_done, tx_overflow;

  logic [15:0] tx_word4;
  logic        tx_csw4, tx_dw4;
  logic        tx_ready4, tx_busy4, tx_data4, tx_data_n4, tx_dval4;
  logic        tx_dval_csw4, tx_done4, tx_overflow4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  encoder_1553_fifo #(.FIFO_DEPTH(4), .HALF_BIT_CLKS(1)) u_dut (
    .enc_clk(clk), .rst_n(rst_n), .tx_word(tx_word), .tx_csw(tx_csw), .tx_dw(tx_dw),
`ifdef ENCODER_1553_PARITY_INJ_EN
    .tx_par_err(1'b0), .tx_sync_err(1'b0),
`endif
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_data(tx_data), .tx_data_n(tx_data_n),
    .tx_dval(tx_dval), .tx_dval_csw(tx_dval_csw), .tx_done(tx_done),
    .tx_overflow(tx_overflow)
  );

  encoder_1553_fifo #(.FIFO_DEPTH(4), .HALF_BIT_CLKS(4)) u_dut4 (
    .enc_clk(clk), .rst_n(rst_n), .tx_word(tx_word4), .tx_csw(tx_csw4), .tx_dw(tx_dw4),
`ifdef ENCODER_1553_PARITY_INJ_EN
    .tx_par_err(1'b0), .tx_sync_err(1'b0),
`endif
    .tx_ready(tx_ready4), .tx_busy(tx_busy4), .tx_data(tx_data4), .tx_data_n(tx_data_n4),
    .tx_dval(tx_dval4), .tx_dval_csw(tx_dval_csw4), .tx_done(tx_done4),
    .tx_overflow(tx_overflow4)
  );

  // ---------------- reference model ----------------
  logic [15:0] q_w[$];
  logic        q_t[$];
  logic exp_dval [MAXK];
  logic exp_data [MAXK];
  logic exp_csw  [MAXK];
  logic exp_done [MAXK];
  int   exp_end;

  // Frame as 40 half-bits, element 39 is sent first.
  function automatic logic [39:0] frame(input logic [15:0] w, input logic csw);
    logic [16:0] b;
    logic [39:0] f;
    b = {w, ~^w};
    f[39:34] = csw ? 6'b111000 : 6'b000111;
    for (int i = 0; i < 17; i++) begin
      f[33-2*i] = b[16-i];
      f[32-2*i] = ~b[16-i];
    end
    return f;
  endfunction

  // Queued words go out back to back starting at sample k0.
  task automatic model_build(input int k0, input int hbc);
    int k;
    logic [39:0] fr;
    for (int i = 0; i < MAXK; i++) begin
      exp_dval[i] = 1'b0; exp_data[i] = 1'b0; exp_csw[i] = 1'b0; exp_done[i] = 1'b0;
    end
    k = k0;
    foreach (q_w[i]) begin
      fr = frame(q_w[i], q_t[i]);
      for (int h = 0; h < 40; h++)
        for (int r = 0; r < hbc; r++) begin
          exp_dval[k] = 1'b1;
          exp_data[k] = fr[39-h];
          exp_csw[k]  = q_t[i];
          exp_done[k] = (h == 39) && (r == hbc - 1);
          k++;
        end
    end
    exp_end = k;
  endtask

  task automatic drive(input logic csw, input logic dw, input logic [15:0] w);
    tx_csw = csw; tx_dw = dw; tx_word = w;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({tx_dval, tx_data, tx_data_n, tx_dval_csw, tx_done, tx_overflow, tx_busy, tx_ready} !== 8'b00000001) begin
      n_errors++;
      $display("FAIL reset_held got=%b exp=00000001",
        {tx_dval, tx_data, tx_data_n, tx_dval_csw, tx_done, tx_overflow, tx_busy, tx_ready});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_dval4, tx_data4, tx_data_n4, tx_dval_csw4, tx_done4, tx_overflow4, tx_busy4, tx_ready4} !== 8'b00000001) begin
      n_errors++;
      $display("FAIL reset_dut4 got=%b exp=00000001",
        {tx_dval4, tx_data4, tx_data_n4, tx_dval_csw4, tx_done4, tx_overflow4, tx_busy4, tx_ready4});
    end
  endtask

  task automatic test_single(input string name, input logic csw, input logic [15:0] w);
    logic [4:0] got, ex;
    q_w.delete(); q_t.delete();
    q_w.push_back(w); q_t.push_back(csw);
    model_build(2, 1);
    drive(csw, !csw, w);
    for (int k = 0; k < exp_end + 3; k++) begin
      @(negedge clk);
      got = {tx_dval, tx_data, tx_data_n, tx_dval_csw, tx_done};
      ex  = {exp_dval[k], exp_data[k], exp_dval[k] & ~exp_data[k], exp_csw[k], exp_done[k]};
      n_checks++;
      if (got !== ex) begin
        n_errors++;
        $display("FAIL %s k=%0d got=%b exp=%b", name, k, got, ex);
      end
      if (k >= 1) begin
        n_checks++;
        if (tx_busy !== (k < exp_end)) begin
          n_errors++;
          $display("FAIL %s_busy k=%0d got=%b exp=%b", name, k, tx_busy, (k < exp_end));
        end
      end
      drive(1'b0, 1'b0, 16'h0000);
    end
  endtask

  task automatic test_contiguous();
    logic [4:0]  got, ex;
    logic [15:0] w[4];
    int ndone = 0;
    w[0] = 16'($urandom); w[1] = 16'h0001; w[2] = 16'h8000; w[3] = 16'h0000;
    q_w.delete(); q_t.delete();
    for (int i = 0; i < 4; i++) begin q_w.push_back(w[i]); q_t.push_back(i == 0); end
    model_build(2, 1);
    drive(1'b1, 1'b0, w[0]);
    for (int k = 0; k < exp_end + 3; k++) begin
      @(negedge clk);
      got = {tx_dval, tx_data, tx_data_n, tx_dval_csw, tx_done};
      ex  = {exp_dval[k], exp_data[k], exp_dval[k] & ~exp_data[k], exp_csw[k], exp_done[k]};
      n_checks++;
      if (got !== ex) begin
        n_errors++;
        $display("FAIL contiguous k=%0d got=%b exp=%b", k, got, ex);
      end
      if (tx_done === 1'b1) ndone++;
      if (k < 3) drive(1'b0, 1'b1, w[k+1]);
      else       drive(1'b0, 1'b0, 16'h0000);
    end
    n_checks++;
    if (ndone != 4) begin
      n_errors++;
      $display("FAIL contiguous_done_count got=%0d exp=4", ndone);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  got, ex;
    logic [15:0] w[4];
    logic        t[4];
    logic        both[4];
    int n;
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 4);
      q_w.delete(); q_t.delete();
      for (int i = 0; i < n; i++) begin
        w[i] = 16'($urandom); t[i] = 1'($urandom); both[i] = 1'($urandom);
        q_w.push_back(w[i]); q_t.push_back(t[i]);
      end
      model_build(2, 1);
      drive(t[0], !t[0] | both[0], w[0]);
      for (int k = 0; k < exp_end + 3; k++) begin
        @(negedge clk);
        got = {tx_dval, tx_data, tx_data_n, tx_dval_csw, tx_done};
        ex  = {exp_dval[k], exp_data[k], exp_dval[k] & ~exp_data[k], exp_csw[k], exp_done[k]};
        n_checks++;
        if (got !== ex) begin
          n_errors++;
          $display("FAIL back_to_back it=%0d k=%0d got=%b exp=%b", it, k, got, ex);
        end
        if (k + 1 < n) drive(t[k+1], !t[k+1] | both[k+1], w[k+1]);
        else           drive(1'b0, 1'b0, 16'h0000);
      end
    end
  endtask

  task automatic test_overflow();
    logic [4:0]  got, ex;
    logic [15:0] w[6];
    q_w.delete(); q_t.delete();
    for (int i = 0; i < 6; i++) begin
      w[i] = 16'($urandom);
      if (i < 5) begin q_w.push_back(w[i]); q_t.push_back(1'b0); end
    end
    model_build(2, 1);
    drive(1'b0, 1'b1, w[0]);
    for (int k = 0; k < exp_end + 3; k++) begin
      @(negedge clk);
      got = {tx_dval, tx_data, tx_data_n, tx_dval_csw, tx_done};
      ex  = {exp_dval[k], exp_data[k], exp_dval[k] & ~exp_data[k], exp_csw[k], exp_done[k]};
      n_checks++;
      if (got !== ex) begin
        n_errors++;
        $display("FAIL overflow_stream k=%0d got=%b exp=%b", k, got, ex);
      end
      n_checks++;
      if (tx_ready !== !(k >= 9 && k <= 41)) begin
        n_errors++;
        $display("FAIL overflow_ready k=%0d got=%b exp=%b", k, tx_ready, !(k >= 9 && k <= 41));
      end
      n_checks++;
      if (tx_overflow !== (k == 10)) begin
        n_errors++;
        $display("FAIL overflow_pulse k=%0d got=%b exp=%b", k, tx_overflow, (k == 10));
      end
      if (k >= 1) begin
        n_checks++;
        if (tx_busy !== (k < exp_end)) begin
          n_errors++;
          $display("FAIL overflow_busy k=%0d got=%b exp=%b", k, tx_busy, (k < exp_end));
        end
      end
      if (k >= 5 && k <= 9) drive(1'b0, 1'b1, w[k-4]);
      else                  drive(1'b0, 1'b0, 16'h0000);
    end
  endtask

  task automatic test_hbc4();
    logic [4:0] got, ex;
    q_w.delete(); q_t.delete();
    q_w.push_back(16'hA5A5); q_t.push_back(1'b0);
    model_build(2, 4);
    tx_csw4 = 1'b0; tx_dw4 = 1'b1; tx_word4 = 16'hA5A5;
    for (int k = 0; k < exp_end + 3; k++) begin
      @(negedge clk);
      got = {tx_dval4, tx_data4, tx_data_n4, tx_dval_csw4, tx_done4};
      ex  = {exp_dval[k], exp_data[k], exp_dval[k] & ~exp_data[k], exp_csw[k], exp_done[k]};
      n_checks++;
      if (got !== ex) begin
        n_errors++;
        $display("FAIL hbc4 k=%0d got=%b exp=%b", k, got, ex);
      end
      tx_dw4 = 1'b0; tx_word4 = 16'h0000;
    end
  endtask

  task automatic test_reset_midword();
    logic [4:0]  got, ex;
    logic [15:0] w[3];
    q_w.delete(); q_t.delete();
    for (int i = 0; i < 3; i++) begin
      w[i] = 16'($urandom); q_w.push_back(w[i]); q_t.push_back(1'b0);
    end
    model_build(2, 1);
    drive(1'b0, 1'b1, w[0]);
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      got = {tx_dval, tx_data, tx_data_n, tx_dval_csw, tx_done};
      ex  = {exp_dval[k], exp_data[k], exp_dval[k] & ~exp_data[k], exp_csw[k], exp_done[k]};
      n_checks++;
      if (got !== ex) begin
        n_errors++;
        $display("FAIL midreset_pre k=%0d got=%b exp=%b", k, got, ex);
      end
      if (k < 2) drive(1'b0, 1'b1, w[k+1]);
      else       drive(1'b0, 1'b0, 16'h0000);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_dval, tx_data, tx_data_n, tx_dval_csw, tx_done, tx_overflow, tx_busy, tx_ready} !== 8'b00000001) begin
      n_errors++;
      $display("FAIL midreset_async got=%b exp=00000001",
        {tx_dval, tx_data, tx_data_n, tx_dval_csw, tx_done, tx_overflow, tx_busy, tx_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_dval, tx_data, tx_data_n, tx_done, tx_busy, tx_ready} !== 6'b000001) begin
        n_errors++;
        $display("FAIL midreset_after k=%0d got=%b exp=000001", k,
          {tx_dval, tx_data, tx_data_n, tx_done, tx_busy, tx_ready});
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0000);
    tx_csw4 = 1'b0; tx_dw4 = 1'b0; tx_word4 = 16'h0000;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single("single_dw", 1'b0, 16'h1234);
    test_single("single_csw", 1'b1, 16'hFFFF);
    test_single("single_dw_rand", 1'b0, 16'($urandom));
    test_contiguous();
    test_back_to_back();
    test_overflow();
    test_hbc4();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encoder_1553_fifo.md
Name: encoder_1553_fifo

Overview:
- Parametrised MIL-STD-1553 Manchester II word encoder with an input word FIFO, real 16-bit data input, odd parity and a programmable half-bit period.
- Accepts command/status and data words from the protocol controller and queues them.
- Transmits queued words contiguously, with no inter-word gap, for 1553 multi-word messages.
- Drives the differential TX pair (tx_data, tx_data_n) toward the transceiver.

Parameters:
FIFO_DEPTH, 4, number of queued words; power of 2, 2..16.
HALF_BIT_CLKS, 1, enc_clk cycles per Manchester half-bit; 1 = 2 MHz enc_clk, 8 = 16 MHz; range 1..64.

Ports:
enc_clk  in  1  encoder clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
tx_word  in  16  word to send; bit 15 transmitted first.
tx_csw  in  1  write strobe; tx_word is a command/status word (sync 111000).
tx_dw  in  1  write strobe; tx_word is a data word (sync 000111).
tx_ready  out  1  FIFO not full; a write is accepted when high.
tx_busy  out  1  high while FIFO is non-empty or a word is in flight.
tx_data  out  1  serial Manchester output, positive leg.
tx_data_n  out  1  negative leg; ~tx_data while tx_dval is high, else 0.
tx_dval  out  1  high on every cycle a half-bit is driven.
tx_dval_csw  out  1  high while the word in flight is a command/status word.
tx_done  out  1  one-cycle pulse on the final clock of each word's last half-bit.
tx_overflow  out  1  one-cycle pulse when a write is dropped because the FIFO is full.

Behaviour:
- Reset: all outputs 0 except tx_ready=1; FIFO emptied; FSM to IDLE. Reset mid-word aborts immediately and the line goes idle low (both legs 0).
- Write acceptance:
  - Write = tx_csw|tx_dw sampled high at a rising edge, storing {type, tx_word}.
  - Both strobes high: treated as a command/status word.
  - A write while full is dropped and tx_overflow pulses; FIFO contents are unchanged.
  - Write and pop in the same cycle while full: the write is accepted.
- Frame: 40 half-bits.
  - 6 sync half-bits: csw 111000, dw 000111.
  - 16 data bits, MSB first: bit 1 -> 10, bit 0 -> 01.
  - Parity bit, encoded the same way; odd parity over the 16 bits (parity = ~^tx_word).
  - Each half-bit is held exactly HALF_BIT_CLKS cycles.
- FSM:
  - IDLE: FIFO non-empty -> LOAD.
  - LOAD: pop the head into the 17-bit shift register plus sync/type registers; one cycle; -> SYNC.
  - SYNC: 6 half-bits -> DATA.
  - DATA: 34 half-bits (data + parity).
  - At the end of the parity half-bit: FIFO non-empty -> SYNC of the next word, with the pop and preload done in that same last cycle and no gap; FIFO empty -> IDLE.
- Latency: a write at edge N into an empty idle encoder -> LOAD at edge N+1 -> tx_dval=1 with the first sync half-bit registered at edge N+2.
- Idle drop: tx_dval falls on the edge after the last parity half-bit ends, unless a contiguous word follows.
- Contiguous words: tx_dval stays high continuously. tx_dval_csw follows each word's type and updates at the first sync half-bit of each word.
- Counters:
  - Half-bit period counter: 0..HALF_BIT_CLKS-1, wrapping.
  - Half-bit index: 0..39, 6 bits, wrapping to 0 on a contiguous reload.
  - FIFO pointers: log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty by pointer compare.
- tx_busy: asserts the edge after the first accepted write; deasserts together with tx_dval after the final word.

Optional Feature:
- Macro: ENCODER_1553_PARITY_INJ_EN.
- Enabled:
  - Adds input tx_par_err (1 bit), sampled with each write and stored in the FIFO entry.
  - When set, that word transmits inverted (even) parity; all other timing is identical.
  - Also adds input tx_sync_err (1 bit): when set, the stored word uses the opposite word type's sync pattern. tx_dval_csw still follows the strobe type.
- Disabled: the ports are absent, the FIFO entry width is 17 bits, and parity is always odd.

Test Plan:
- HALF_BIT_CLKS=1, one tx_dw with 0x1234 at edge N -> tx_dval high edges N+2..N+41. tx_data = 000111 then 01010110 01011001 01011010 01100101, then parity 01 (5 ones, parity 0). tx_done pulse on cycle N+41. tx_dval_csw stays 0.
- tx_csw 0xFFFF -> sync 111000, 32 half-bits of 10, parity 10 (parity 1); tx_dval_csw high throughout.
- One csw plus 3 dw (0x0001, 0x8000, 0x0000) written on consecutive cycles -> tx_dval continuously high for 160 cycles with no gap. Exactly 4 tx_done pulses, 40 cycles apart.
- FIFO_DEPTH=4 overflow: 6 writes while the first word is in flight -> tx_ready low once 4 words are queued. Exactly 1 tx_overflow pulse; 5 words transmitted; the last write is lost.
- HALF_BIT_CLKS=4, dw 0xA5A5 -> each half-bit held 4 cycles; frame 160 cycles; tx_data_n = ~tx_data throughout.
- rst_n low mid-DATA of word 2 of 3 -> all outputs 0 asynchronously. After release: tx_ready=1, tx_busy=0, no residual transmission.
